vaelix_key_courier: RTL and testbench



---
 rtl/vaelix_courier_pkg.sv | 24 ++
 rtl/vaelix_key_courier_if.sv | 28 ++
 rtl/vaelix_sync2.sv | 25 ++
 rtl/vaelix_key_courier.sv | 140 ++++++++++++++
 tb/tb_vaelix_key_courier.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vaelix_courier_pkg.sv
// Shared types and constants for the key courier: FSM state encoding,
// default timing parameters and the blank key value.
package vaelix_courier_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RESULT  = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_e;

    localparam int DEF_SETTLE_CYCLES  = 4;
    localparam int DEF_TIMEOUT_CYCLES = 16;
    localparam int DEF_MAX_FAILS      = 3;

    localparam logic [7:0] KEY_BLANK = 8'h00;

    // Denial counter increment that sticks at its maximum value.
    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

endpackage

// File: rtl/vaelix_key_courier_if.sv
// Signal bundle between the host/lock side and the key courier.
// The master side drives requests and the lock status pin; the slave
// side (the courier) drives the key port and status outputs.
interface vaelix_key_courier_if;

    logic       ena;
    logic       start;
    logic [7:0] key_in;
    logic       auth_in;
    logic [7:0] key_out;
    logic       key_valid;
    logic       busy;
    logic       done;
    logic       granted;
    logic [1:0] fail_count;
    logic       lockout;

    modport master (
        output ena, start, key_in, auth_in,
        input  key_out, key_valid, busy, done, granted, fail_count, lockout
    );

    modport slave (
        input  ena, start, key_in, auth_in,
        output key_out, key_valid, busy, done, granted, fail_count, lockout
    );

endinterface

// File: rtl/vaelix_sync2.sv
// Two-flop synchronizer for a single asynchronous level signal.
module vaelix_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the raw input through two flops; both clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/vaelix_key_courier.sv
// Key courier: presents a captured key to a lock, lets it settle, then
// watches the synchronized status pin for a grant within a timeout.
// Consecutive denials are counted and lock the block out until reset.
module vaelix_key_courier
    import vaelix_courier_pkg::*;
#(
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int MAX_FAILS      = DEF_MAX_FAILS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vaelix_key_courier_if.slave  cif
);

    // Last counter value of each phase; the counter starts at 0 on entry.
    localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] FAIL_LIMIT   = 2'(MAX_FAILS);

    logic auth_s;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] key_q, key_d;
    logic       granted_q, granted_d;
    logic [1:0] fail_q, fail_d;
    logic [7:0] key_out_q, key_out_d;
    logic       key_valid_q, key_valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       lockout_q, lockout_d;

    vaelix_sync2 u_auth_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (cif.auth_in),
        .q_o   (auth_s)
    );

    // State, shared settle/timeout counter, captured key and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            key_q       <= KEY_BLANK;
            granted_q   <= 1'b0;
            fail_q      <= 2'd0;
            key_out_q   <= KEY_BLANK;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            lockout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            granted_q   <= granted_d;
            fail_q      <= fail_d;
            key_out_q   <= key_out_d;
            key_valid_q <= key_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            lockout_q   <= lockout_d;
        end
    end

    // Next-state logic; outputs are derived from the next state so they
    // line up with the state once registered.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        key_d     = key_q;
        granted_d = granted_q;
        fail_d    = fail_q;

        case (state_q)
            ST_IDLE: begin
                if (cif.start && cif.ena) begin
                    key_d   = cif.key_in;
                    cnt_d   = 8'd0;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (!cif.ena) begin
                    cnt_d   = 8'd0;
                    state_d = ST_IDLE;
                end else if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_WAIT: begin
                // Abort beats everything; a grant beats the final timeout cycle.
                if (!cif.ena) begin
                    cnt_d   = 8'd0;
                    state_d = ST_IDLE;
                end else if (auth_s) begin
                    granted_d = 1'b1;
                    fail_d    = 2'd0;
                    state_d   = ST_RESULT;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    granted_d = 1'b0;
                    fail_d    = sat_inc2(fail_q);
                    state_d   = ST_RESULT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESULT: begin
                cnt_d   = 8'd0;
                state_d = (fail_q == FAIL_LIMIT) ? ST_LOCKOUT : ST_IDLE;
            end
            ST_LOCKOUT: begin
                state_d = ST_LOCKOUT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        key_valid_d = (state_d == ST_DRIVE) || (state_d == ST_WAIT);
        key_out_d   = key_valid_d ? key_d : KEY_BLANK;
        busy_d      = key_valid_d || (state_d == ST_RESULT);
        done_d      = (state_d == ST_RESULT);
        lockout_d   = (fail_d == FAIL_LIMIT);
    end

    assign cif.key_out    = key_out_q;
    assign cif.key_valid  = key_valid_q;
    assign cif.busy       = busy_q;
    assign cif.done       = done_q;
    assign cif.granted    = granted_q;
    assign cif.fail_count = fail_q;
    assign cif.lockout    = lockout_q;

endmodule

// File: tb/tb_vaelix_key_courier.sv
// Bench for the key courier: a stimulus process issues presentations and
// queues the expected outcome of each; a monitor follows every valid-key
// run and compares its ending (done pulse or abort) against the queue.
module tb_vaelix_key_courier;

    localparam int SETTLE    = 4;
    localparam int TIMEOUT   = 16;
    localparam int MAX_FAILS = 3;

    typedef struct {
        logic [7:0] key;
        int         run;
        bit         aborted;
        bit         granted;
        int         fail;
        bit         lock;
    } exp_t;

    logic clk;
    logic rst_n;

    int errors = 0;
    int checks = 0;

    exp_t exp_q[$];

    // Reference model: result of the last completed presentation.
    bit m_granted = 1'b0;
    int m_fail    = 0;
    bit m_lock    = 1'b0;

    vaelix_key_courier_if cif ();

    vaelix_key_courier #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .MAX_FAILS      (MAX_FAILS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cif   (cif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_key_out"},    int'(cif.key_out), 0);
        chk({tag, "_key_valid"},  int'(cif.key_valid), 0);
        chk({tag, "_busy"},       int'(cif.busy), 0);
        chk({tag, "_done"},       int'(cif.done), 0);
        chk({tag, "_granted"},    int'(cif.granted), 0);
        chk({tag, "_fail_count"}, int'(cif.fail_count), 0);
        chk({tag, "_lockout"},    int'(cif.lockout), 0);
    endtask

    // Assert reset mid-cycle, check outputs before the next edge, release.
    task automatic do_reset(input string tag, input bit expect_active);
        @(posedge clk);
        #2;
        if (expect_active) chk({tag, "_pre_key_valid"}, int'(cif.key_valid), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        exp_q.delete();
        m_granted = 1'b0;
        m_fail    = 0;
        m_lock    = 1'b0;
        cif.start   = 1'b0;
        cif.auth_in = 1'b0;
        cif.ena     = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // One presentation. k: WAIT cycle (1-based) in which the synchronized
    // status first reads high, 0 = never. d: presentation cycle in which
    // ena is low at the closing edge, 0 = no abort.
    task automatic present(input logic [7:0] key, input int k, input int d);
        exp_t e;
        bit   grant;
        int   len;
        grant = (k >= 1) && (k <= TIMEOUT);
        len   = SETTLE + (grant ? k : TIMEOUT);
        if (!m_lock) begin
            e.key     = key;
            e.aborted = (d > 0);
            e.run     = e.aborted ? d : len;
            if (!e.aborted) begin
                m_granted = grant;
                m_fail    = grant ? 0 : ((m_fail < 3) ? m_fail + 1 : 3);
                m_lock    = (m_fail >= MAX_FAILS);
            end
            e.granted = m_granted;
            e.fail    = m_fail;
            e.lock    = m_lock;
            exp_q.push_back(e);
        end
        @(negedge clk);
        cif.start   = 1'b1;
        cif.key_in  = key;
        cif.auth_in = 1'b0;
        @(negedge clk);
        cif.start  = 1'b0;
        cif.key_in = 8'($urandom);
        // Two synchronizer stages: raise the pin two edges ahead of cycle k.
        for (int n = 1; n <= len + 1; n++) begin
            if (k >= 1 && n == SETTLE - 2 + k) cif.auth_in = 1'b1;
            if (d > 0 && n == d)     cif.ena = 1'b0;
            if (d > 0 && n == d + 1) cif.ena = 1'b1;
            @(negedge clk);
        end
        cif.auth_in = 1'b0;
        cif.ena     = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Monitor: follows each valid-key run and scores how it ends.
    initial begin : monitor
        int   run;
        exp_t e;
        run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run = 0;
            end else begin
                if (cif.key_valid) begin
                    run++;
                    if (exp_q.size() == 0) chk("key_valid_unexpected", 1, 0);
                    else chk("key_out_driven", int'(cif.key_out), int'(exp_q[0].key));
                end else begin
                    chk("key_out_blank", int'(cif.key_out), 0);
                    if (run > 0 || cif.done) begin
                        if (exp_q.size() == 0) begin
                            chk("event_unexpected", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("done_pulse",   int'(cif.done), e.aborted ? 0 : 1);
                            chk("valid_cycles", run, e.run);
                            chk("granted",      int'(cif.granted), int'(e.granted));
                            chk("fail_count",   int'(cif.fail_count), e.fail);
                            chk("lockout",      int'(cif.lockout), int'(e.lock));
                            $display("txn key=%02h valid_cycles=%0d done=%0b granted=%0b fail_count=%0d lockout=%0b",
                                     e.key, run, cif.done, cif.granted, cif.fail_count, cif.lockout);
                        end
                        run = 0;
                    end
                end
                chk("busy", int'(cif.busy), int'(cif.key_valid | cif.done));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int k;
        int d;
        int len;
        rst_n       = 1'b1;
        cif.ena     = 1'b1;
        cif.start   = 1'b0;
        cif.key_in  = 8'h00;
        cif.auth_in = 1'b0;

        do_reset("power_on", 1'b0);

        // Grant: status seen in WAIT cycle 4.
        present(8'hB6, 4, 0);

        // Three denials lead to lockout; a fourth start is ignored.
        present(8'h5A, 0, 0);
        present(8'h5A, 0, 0);
        present(8'h5A, 0, 0);
        present(8'h5A, 0, 0);
        chk("lock_lockout",    int'(cif.lockout), 1);
        chk("lock_busy",       int'(cif.busy), 0);
        chk("lock_fail_count", int'(cif.fail_count), 3);
        cif.ena = 1'b0;
        repeat (3) @(negedge clk);
        chk("lock_ena_low_lockout", int'(cif.lockout), 1);
        cif.ena = 1'b1;
        do_reset("after_lockout", 1'b0);

        // Recovery: two denials then a grant.
        present(8'h11, 0, 0);
        present(8'h22, 0, 0);
        present(8'h33, 5, 0);

        // Abort in DRIVE cycle 2 after one denial; counters must hold.
        present(8'h44, 0, 0);
        present(8'h55, 0, 2);
        chk("abort_fail_held", int'(cif.fail_count), 1);

        // Reset while in WAIT.
        m_lock = 1'b0;
        begin
            exp_t e;
            e.key = 8'hC3; e.run = 0; e.aborted = 1'b1;
            e.granted = 1'b0; e.fail = 0; e.lock = 1'b0;
            exp_q.push_back(e);
        end
        @(negedge clk);
        cif.start  = 1'b1;
        cif.key_in = 8'hC3;
        @(negedge clk);
        cif.start = 1'b0;
        repeat (SETTLE + 2) @(negedge clk);
        do_reset("mid_wait_reset", 1'b1);

        // Timeout boundary: grant on the last WAIT cycle, deny one later.
        present(8'h7E, TIMEOUT, 0);
        present(8'h7F, TIMEOUT + 1, 0);

        // Randomized presentations.
        for (int i = 0; i < 30; i++) begin
            k   = $urandom_range(0, TIMEOUT + 3);
            len = SETTLE + ((k >= 1 && k <= TIMEOUT) ? k : TIMEOUT);
            d   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, len) : 0;
            present(8'($urandom), k, d);
            if (m_lock) do_reset("random_lockout", 1'b0);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
